// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, instruction
// stride and the return-address-stack pointer width helper.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } seq_state_t;

   localparam int unsigned INSN_BYTES = 4;

   // Pointer width for a power-of-two stack depth; never narrower than one bit.
   function automatic int unsigned ras_ptr_w(input int unsigned depth);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < depth) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-request and control bundle between the PC sequencer (master) and the
// fetch/branch side (slave).
interface pc_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            pc_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vector;
   logic            halt_req;
   logic            call_hint;
   logic            ret_hint;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            pc_misaligned;
   logic            halted;

   modport master (
      input  pc_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
             halt_req, call_hint, ret_hint,
      output pc, pc_valid, pc_misaligned, halted
   );

   modport slave (
      output pc_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
             halt_req, call_hint, ret_hint,
      input  pc, pc_valid, pc_misaligned, halted
   );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push past full overwrites the oldest entry,
// pop when empty is ignored, push+pop together replaces the top in place.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty
);
   localparam int unsigned PW   = ras_ptr_w(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   sp;
   logic [PW-1:0]   sp_inc;
   logic [PW:0]     count;
   logic            pop_ok;

   assign sp_inc = sp + 1'b1;
   assign empty  = (count == '0);
   assign pop_ok = pop && !empty;
   assign top    = mem[sp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp    <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (push && pop_ok) begin
         mem[sp] <= push_data;
      end else if (push) begin
         // Wrapping sp onto the oldest slot is what makes overflow overwrite it.
         sp          <= sp_inc;
         mem[sp_inc] <= push_data;
         if (count != FULL) count <= count + 1'b1;
      end else if (pop_ok) begin
         sp    <= sp - 1'b1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with BOOT/RUN/HALT control, trap/redirect override and an
// optional return-address stack enabled by macro PC_SEQ_RAS_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic       pll_1_200MHz,
   input  logic       pll_1_rst_synced,
   pc_sequencer_if.master bus
);
   seq_state_t      state_q, state_n;
   logic [XLEN-1:0] pc_q, pc_n;
   logic            mis_q, mis_n;
   logic [XLEN-1:0] seq_pc;
   logic            transfer;
   logic            ras_push, ras_pop, ras_clear, ras_empty;
   logic [XLEN-1:0] ras_top;

   assign seq_pc   = pc_q + XLEN'(INSN_BYTES);
   assign transfer = (state_q == ST_RUN) && bus.pc_ready;

   always_ff @(posedge pll_1_200MHz or posedge pll_1_rst_synced) begin
      if (pll_1_rst_synced) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         mis_q   <= mis_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      pc_n      = pc_q;
      mis_n     = 1'b0;
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      ras_clear = 1'b0;
      if (bus.trap_valid) begin
         pc_n      = {bus.trap_vector[XLEN-1:2], 2'b00};
         mis_n     = |bus.trap_vector[1:0];
         state_n   = ST_RUN;
         ras_clear = 1'b1;
      end else if (bus.redirect_valid) begin
         pc_n    = {bus.redirect_target[XLEN-1:2], 2'b00};
         mis_n   = |bus.redirect_target[1:0];
         state_n = ST_RUN;
      end else if (bus.halt_req) begin
         state_n = ST_HALT;
      end else if (state_q != ST_RUN) begin
         // Covers both BOOT exit and HALT release; pc is kept as is.
         state_n = ST_RUN;
      end else if (transfer) begin
         pc_n     = (bus.ret_hint && !ras_empty) ? ras_top : seq_pc;
         ras_push = bus.call_hint;
         ras_pop  = bus.ret_hint;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_valid      = (state_q == ST_RUN);
   assign bus.halted        = (state_q == ST_HALT);
   assign bus.pc_misaligned = mis_q;

`ifdef PC_SEQ_RAS_EN
   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (pll_1_200MHz),
      .rst       (pll_1_rst_synced),
      .clear     (ras_clear),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .empty     (ras_empty)
   );
`else
   logic unused_ras;
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
   assign unused_ras = ^{ras_push, ras_pop, ras_clear, 1'(RAS_DEPTH)};
`endif

endmodule
